life_gen_scheduler: RTL and testbench

- Schedules Game-of-Life generation updates and shares the single-port cell-state RAM between two requesters: the VGA pixel-fetch path (display) and the life update engine.
- Display always has priority. The engine reaches the RAM only during vertical blanking, while a generation is in progress.
- A new generation starts on a frame boundary every FRAMES_PER_GEN frames (run mode), or once on request (step mode).
- Sits between the VGA timing generator, the cell RAM and the update engine.

---
 rtl/life_pkg.sv | 16 +
 rtl/life_mem_arbiter.sv | 68 ++++++
 rtl/life_gen_scheduler.sv | 140 ++++++++++++++
 tb/tb_life_gen_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life generation scheduler slice:
// FSM encoding, address width default and grid geometry.
package life_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int GRID_W      = 64;
    localparam int GRID_H      = 64;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/life_mem_arbiter.sv
// Cell-RAM port sharing: display always wins, engine only while busy in vblank.
// Read data is returned with rvalid exactly one cycle after a granted read.
module life_mem_arbiter
    import life_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_busy,
    input  logic              i_vblank,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    input  logic              i_eng_req,
    input  logic              i_eng_we,
    input  logic [ADDR_W-1:0] i_eng_addr,
    input  logic              i_eng_wdata,
    input  logic              i_mem_rdata,
    output logic              o_disp_rvalid,
    output logic              o_disp_rdata,
    output logic              o_eng_gnt,
    output logic              o_eng_rvalid,
    output logic              o_eng_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic              o_mem_wdata
);

    logic              w_eng_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_disp_rvalid;
    logic              r_eng_rvalid;

    // Handshake: the engine holds eng_req/eng_addr until it sees eng_gnt; nothing is queued.
    assign w_eng_gnt = i_eng_req & i_busy & i_vblank & ~i_disp_req;

    always_comb begin
        w_mem_addr = r_last_addr;
        if (i_disp_req) begin
            w_mem_addr = i_disp_addr;
        end else if (w_eng_gnt) begin
            w_mem_addr = i_eng_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_addr   <= '0;
            r_disp_rvalid <= 1'b0;
            r_eng_rvalid  <= 1'b0;
        end else begin
            r_last_addr   <= w_mem_addr;
            r_disp_rvalid <= i_disp_req;
            r_eng_rvalid  <= w_eng_gnt & ~i_eng_we;
        end
    end

    assign o_eng_gnt     = w_eng_gnt;
    assign o_mem_addr    = w_mem_addr;
    assign o_mem_we      = w_eng_gnt & i_eng_we;
    assign o_mem_wdata   = w_eng_gnt & i_eng_we & i_eng_wdata;
    assign o_disp_rvalid = r_disp_rvalid;
    assign o_eng_rvalid  = r_eng_rvalid;
    assign o_disp_rdata  = r_disp_rvalid & i_mem_rdata;
    assign o_eng_rdata   = r_eng_rvalid & i_mem_rdata;

endmodule

// File: rtl/life_gen_scheduler.sv
// Starts Game-of-Life generations on frame boundaries (run or step mode),
// tracks completed generations and flags missed schedule points.
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int FRAMES_PER_GEN = 30,
    parameter int GEN_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vblank,
    input  logic                 frame_tick,
    input  logic                 run_en,
    input  logic                 step,
    input  logic                 clr_overrun,
    input  logic                 disp_req,
    input  logic [ADDR_W-1:0]    disp_addr,
    output logic                 disp_rvalid,
    output logic                 disp_rdata,
    input  logic                 eng_req,
    input  logic                 eng_we,
    input  logic [ADDR_W-1:0]    eng_addr,
    input  logic                 eng_wdata,
    output logic                 eng_gnt,
    output logic                 eng_rvalid,
    output logic                 eng_rdata,
    output logic                 gen_start,
    input  logic                 gen_done,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic                 mem_wdata,
    input  logic                 mem_rdata,
    output logic                 busy,
    output logic [GEN_CNT_W-1:0] gen_count,
    output logic                 overrun,
    output sched_state_t         dbg_state
);

    localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(FRAMES_PER_GEN - 1);

    sched_state_t             r_state;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;
    logic                     r_step_pend;
    logic                     r_gen_start;
    logic                     r_busy;
    logic                     r_overrun;
    logic [GEN_CNT_W-1:0]     r_gen_count;
    logic                     w_sched;

    assign w_sched = frame_tick & (r_step_pend | (run_en & (r_frame_cnt == LAST_FRAME)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_step_pend <= 1'b0;
            r_gen_start <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_gen_start <= 1'b0;

            if (!run_en || w_sched) begin
                r_frame_cnt <= '0;
            end else if (frame_tick && r_frame_cnt != LAST_FRAME) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end

            // A step arriving with a schedule point survives for the next frame.
            if (step) begin
                r_step_pend <= 1'b1;
            end else if (w_sched) begin
                r_step_pend <= 1'b0;
            end

            if (w_sched && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_sched) begin
                        r_state     <= ST_START;
                        r_gen_start <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
                ST_RUN: begin
                    if (gen_done) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_gen_count <= r_gen_count + GEN_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gen_start = r_gen_start;
    assign busy      = r_busy;
    assign overrun   = r_overrun;
    assign gen_count = r_gen_count;
    assign dbg_state = r_state;

    life_mem_arbiter #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_busy        (r_busy),
        .i_vblank      (vblank),
        .i_disp_req    (disp_req),
        .i_disp_addr   (disp_addr),
        .i_eng_req     (eng_req),
        .i_eng_we      (eng_we),
        .i_eng_addr    (eng_addr),
        .i_eng_wdata   (eng_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_disp_rvalid (disp_rvalid),
        .o_disp_rdata  (disp_rdata),
        .o_eng_gnt     (eng_gnt),
        .o_eng_rvalid  (eng_rvalid),
        .o_eng_rdata   (eng_rdata),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_mem_wdata   (mem_wdata)
    );

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed + randomized bench for life_gen_scheduler against a frame-level
// behavioural model of scheduling and a shadow copy of the cell RAM.
`timescale 1ns/1ps
module tb_life_gen_scheduler;
    import life_pkg::*;

    localparam int AW        = 12;
    localparam int FPG       = 3;
    localparam int GW        = 16;
    localparam int FRAME_LEN = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vblank = 1'b0;
    logic          frame_tick = 1'b0;
    logic          run_en = 1'b0;
    logic          step = 1'b0;
    logic          clr_overrun = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          eng_req = 1'b0;
    logic          eng_we = 1'b0;
    logic [AW-1:0] eng_addr = '0;
    logic          eng_wdata = 1'b0;
    logic          gen_done = 1'b0;
    logic          mem_rdata;
    logic          disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata;
    logic          gen_start, mem_we, mem_wdata, busy, overrun;
    logic [AW-1:0] mem_addr;
    logic [GW-1:0] gen_count;
    sched_state_t  dbg_state;

    always #5 clk = ~clk;

    life_gen_scheduler #(.ADDR_W(AW), .FRAMES_PER_GEN(FPG), .GEN_CNT_W(GW)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .frame_tick(frame_tick),
        .run_en(run_en), .step(step), .clr_overrun(clr_overrun),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .gen_start(gen_start), .gen_done(gen_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .gen_count(gen_count), .overrun(overrun), .dbg_state(dbg_state)
    );

    // Single-port cell RAM with one-cycle read latency.
    bit ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int            total = 0;
    int            bad = 0;
    bit            m_busy, m_pend, m_overrun;
    int            m_frames;
    logic [GW-1:0] m_count;
    logic [AW-1:0] m_last_addr;
    bit            shadow [0:(1<<AW)-1];
    int            done_in;
    int            lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_busy = 0; m_pend = 0; m_overrun = 0; m_frames = 0;
        m_count = '0; m_last_addr = '0; done_in = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gen_start"}, gen_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_gen_count"}, gen_count, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_disp_rvalid"}, disp_rvalid, 0);
        check({tag, "_disp_rdata"}, disp_rdata, 0);
        check({tag, "_eng_rvalid"}, eng_rvalid, 0);
        check({tag, "_eng_rdata"}, eng_rdata, 0);
        check({tag, "_eng_gnt"}, eng_gnt, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic set_run(input logic v);
        run_en = v;
        if (!v) m_frames = 0;
    endtask

    task automatic pulse_step();
        step = 1; tick(); step = 0;
        m_pend = 1;
    endtask

    task automatic pulse_clr();
        clr_overrun = 1; tick(); clr_overrun = 0;
        m_overrun = 0;
        check("clr_overrun", overrun, m_overrun);
    endtask

    task automatic pulse_done();
        gen_done = 1; tick(); gen_done = 0;
        if (m_busy) begin
            m_busy = 0;
            m_count = m_count + 1'b1;
        end
        check("done_count", gen_count, m_count);
        check("done_busy", busy, m_busy);
    endtask

    // One video frame: frame_tick first, engine answers gen_done after 'lat' cycles.
    task automatic frame();
        bit cond, exp_start;
        cond = m_pend || (run_en && (m_frames + 1 >= FPG));
        exp_start = 0;
        if (cond) begin
            m_pend = 0;
            m_frames = 0;
            if (m_busy) m_overrun = 1;
            else begin
                exp_start = 1;
                m_busy = 1;
                done_in = lat;
            end
        end else if (run_en) begin
            m_frames++;
        end
        frame_tick = 1; vblank = 1; tick(); frame_tick = 0;
        check("gen_start", gen_start, exp_start);
        check("overrun", overrun, m_overrun);
        for (int c = 1; c < FRAME_LEN; c++) begin
            if (c == 10) vblank = 0;
            if (m_busy && done_in > 0) done_in--;
            if (m_busy && done_in == 0) begin
                done_in = -1;
                pulse_done();
            end else begin
                tick();
            end
            if (c == 1) begin
                check("gen_start_one_cycle", gen_start, 0);
                check("busy", busy, m_busy);
            end
        end
        check("frame_count", gen_count, m_count);
    endtask

    task automatic mem_cycle(input bit dr, input logic [AW-1:0] da, input bit er, input bit ew,
                             input logic [AW-1:0] ea, input bit ed, input bit vb);
        bit eg, n_dv, n_dd, n_ev, n_ed;
        disp_req = dr; disp_addr = da; eng_req = er; eng_we = ew;
        eng_addr = ea; eng_wdata = ed; vblank = vb;
        #1;
        eg = er && m_busy && vb && !dr;
        check("eng_gnt", eng_gnt, eg);
        if (dr) m_last_addr = da;
        else if (eg) m_last_addr = ea;
        check("mem_addr", mem_addr, m_last_addr);
        check("mem_we", mem_we, eg && ew);
        if (eg && ew) check("mem_wdata", mem_wdata, ed);
        n_dv = dr; n_dd = shadow[da];
        n_ev = eg && !ew; n_ed = shadow[ea];
        if (eg && ew) shadow[ea] = ed;
        tick();
        check("disp_rvalid", disp_rvalid, n_dv);
        check("disp_rdata", disp_rdata, n_dv & n_dd);
        check("eng_rvalid", eng_rvalid, n_ev);
        check("eng_rdata", eng_rdata, n_ev & n_ed);
    endtask

    initial begin
        model_reset();
        lat = 10;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1;
        tick();

        // Run mode: a generation every FPG-th frame, engine answers after 10 cycles.
        set_run(1);
        repeat (9) frame();
        check("run_three_gens", gen_count, 3);
        check("run_no_overrun", overrun, 0);

        // Step mode: two steps collapse into one generation.
        set_run(0);
        pulse_step();
        pulse_step();
        repeat (6) frame();
        check("step_one_gen", gen_count, 4);
        pulse_done();

        // Withheld gen_done across a schedule point.
        set_run(1);
        lat = -1;
        repeat (6) frame();
        check("overrun_set", overrun, 1);
        pulse_done();
        pulse_clr();
        lat = 10;
        repeat (3) frame();

        // Arbitration while a generation runs.
        set_run(0);
        lat = -1;
        pulse_step();
        frame();
        mem_cycle(1, 12'h7, 1, 1, 12'h5, 1, 1);
        mem_cycle(0, 12'h0, 1, 1, 12'h5, 1, 1);
        for (int i = 0; i < 100; i++) mem_cycle(0, 12'h0, 1, 0, 12'h5, 0, 0);
        mem_cycle(0, 12'h0, 1, 0, 12'h5, 0, 1);
        for (int i = 0; i < 300; i++) begin
            mem_cycle(1'($urandom_range(1)), AW'($urandom_range(15)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), AW'($urandom_range(15)), 1'($urandom_range(1)),
                      1'($urandom_range(1)));
        end
        mem_cycle(0, 12'h0, 0, 0, 12'h0, 0, 0);
        pulse_done();

        // Reset in the middle of a generation.
        lat = -1;
        pulse_step();
        frame();
        tick();
        reset_n = 0;
        #1;
        model_reset();
        check_all_zero("mid_reset");
        tick();
        reset_n = 1;
        tick();
        pulse_step();
        lat = 5;
        frame();
        check("after_reset_count", gen_count, 1);

        // Randomized frames: mode changes, steps, engine latency spanning frames.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(5) == 0) set_run(!run_en);
            if ($urandom_range(3) == 0) pulse_step();
            lat = $urandom_range(45, 2);
            frame();
            if (m_overrun && $urandom_range(1) == 1) pulse_clr();
        end
        if (m_busy) begin
            done_in = -1;
            pulse_done();
        end
        check("final_count", gen_count, m_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
